// File: rtl/led_pkg.sv
// Shared constants and types for the LED PWM output stage.
package led_pkg;

  localparam int unsigned CLK_HZ       = 6_000_000;
  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned DEF_FADE_DIV = CLK_HZ / 1000;

  typedef logic [DEF_PWM_BITS-1:0] level_t;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating fade level, period-aligned shadow and registered PWM compare.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned UP_STEP   = 16,
  parameter int unsigned DOWN_STEP = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                load,
  input  logic                enable,
  input  logic                req,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                active,
  output logic                led
);

  localparam logic [PWM_BITS:0] UpInc = (PWM_BITS + 1)'(UP_STEP);
  localparam logic [PWM_BITS:0] DnDec = (PWM_BITS + 1)'(DOWN_STEP);

  logic [PWM_BITS:0]   sum;
  logic [PWM_BITS:0]   diff;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] level_d;
  logic [PWM_BITS-1:0] shadow_q;
  logic                led_q;

  // The extra top bit flags overflow on the sum and borrow on the difference.
  always_comb begin
    sum     = {1'b0, level_q} + UpInc;
    diff    = {1'b0, level_q} - DnDec;
    level_d = level_q;
    if (tick && enable) begin
      if (req) begin
        level_d = sum[PWM_BITS] ? '1 : sum[PWM_BITS-1:0];
      end else begin
        level_d = diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= '0;
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      // Shadow takes the pre-tick level so duty never changes inside a period.
      if (load) begin
        shadow_q <= level_q;
      end
      led_q <= enable && (pwm_cnt < shadow_q);
    end
  end

  assign active = |level_q;
  assign led    = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// LED output stage: shared PWM and fade timebase driving N_CH fading channels.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned N_CH      = 6,
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned FADE_DIV  = DEF_FADE_DIV,
  parameter int unsigned UP_STEP   = 16,
  parameter int unsigned DOWN_STEP = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] led_out,
  output logic            busy,
  output logic            period_start
);

  localparam int unsigned FadeW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FadeW-1:0]    fade_cnt;
  logic                tick;
  logic                load;
  logic                busy_q;
  logic [N_CH-1:0]     ch_active;

  assign tick = (fade_cnt == FadeW'(FADE_DIV - 1));
  assign load = (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt  <= '0;
      fade_cnt <= '0;
      busy_q   <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      fade_cnt <= tick ? '0 : fade_cnt + 1'b1;
      busy_q   <= |ch_active;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .UP_STEP   (UP_STEP),
      .DOWN_STEP (DOWN_STEP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .load    (load),
      .enable  (enable),
      .req     (req[i]),
      .pwm_cnt (pwm_cnt),
      .active  (ch_active[i]),
      .led     (led_out[i])
    );
  end

  assign busy         = busy_q;
  assign period_start = (pwm_cnt == '0);

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with a cycle scoreboard and duty-count checks.
module tb_led_fade_pwm;

  localparam int N  = 6;
  localparam int PB = 4;
  localparam int FD = 4;
  localparam int UP = 4;
  localparam int DN = 2;
  localparam int LMAX = (1 << PB) - 1;
  localparam int PER  = 1 << PB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] led_out;
  logic         busy;
  logic         period_start;

  always #5 clk = ~clk;

  led_fade_pwm #(
    .N_CH      (N),
    .PWM_BITS  (PB),
    .FADE_DIV  (FD),
    .UP_STEP   (UP),
    .DOWN_STEP (DN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req          (req),
    .led_out      (led_out),
    .busy         (busy),
    .period_start (period_start)
  );

  typedef struct packed {
    logic [N-1:0] led;
    logic         bsy;
    logic         ps;
  } obs_t;

  obs_t         sb_q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           m_pwm = 0;
  int           m_fade = 0;
  int           m_lvl[N];
  int           m_shd[N];
  logic [N-1:0] m_led = '0;
  logic         m_busy = 1'b0;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Behavioural reference: advance one clock with the inputs now applied.
  task automatic model_step();
    logic [N-1:0] nled;
    logic         nbusy;
    bit           tk;
    int           nl;
    if (rst) begin
      m_pwm  = 0;
      m_fade = 0;
      m_led  = '0;
      m_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_lvl[i] = 0;
        m_shd[i] = 0;
      end
    end else begin
      tk    = (m_fade == FD - 1);
      nbusy = 1'b0;
      nled  = '0;
      for (int i = 0; i < N; i++) begin
        nled[i] = enable && (m_pwm < m_shd[i]);
        if (m_lvl[i] != 0) nbusy = 1'b1;
        nl = m_lvl[i];
        if (tk && enable) begin
          if (req[i]) nl = (m_lvl[i] + UP > LMAX) ? LMAX : m_lvl[i] + UP;
          else        nl = (m_lvl[i] - DN < 0) ? 0 : m_lvl[i] - DN;
        end
        if (m_pwm == PER - 1) m_shd[i] = m_lvl[i];
        m_lvl[i] = nl;
      end
      m_pwm  = (m_pwm + 1) % PER;
      m_fade = (m_fade + 1) % FD;
      m_led  = nled;
      m_busy = nbusy;
    end
    sb_q.push_back({m_led, m_busy, (m_pwm == 0)});
  endtask

  task automatic step();
    obs_t want;
    obs_t got;
    model_step();
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    got  = {led_out, busy, period_start};
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL sb cyc=%0d observed=%h expected=%h", cyc, got, want);
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  int cnt;
  int other;
  int ps_at;
  int ps_n;
  int hi;
  bit done;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = 0;
      m_shd[i] = 0;
    end

    // Reset with all requests low.
    req = '0;
    enable = 1'b1;
    do_reset(3);
    check("rst_ps0", int'(period_start), 1);
    check("rst_led", int'(led_out), 0);
    check("rst_busy", int'(busy), 0);
    ps_n = 0;
    ps_at = -1;
    for (int t = 0; t < 20; t++) begin
      step();
      if (period_start) begin
        ps_n++;
        if (ps_at < 0) ps_at = t + 1;
      end
    end
    check("rst_ps_count", ps_n, 1);
    check("rst_ps_at", ps_at, 16);

    // Fade up on channel 0.
    req = 6'b000001;
    do_reset(1);
    cnt = 0;
    hi = 0;
    other = 0;
    for (int t = 0; t < 48; t++) begin
      step();
      if (t + 1 >= 17 && t + 1 <= 32 && led_out[0]) hi++;
      if (t + 1 >= 33 && led_out[0]) cnt++;
      if (led_out[N-1:1] != '0) other++;
    end
    check("up_duty12", hi, 12);
    check("up_duty15", cnt, 15);
    check("up_other", other, 0);
    check("up_busy", int'(busy), 1);

    // Fade down from 15: busy falls after the eighth decrement.
    req = '0;
    hi = 0;
    done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      step();
      if (busy) hi++;
      else done = 1;
    end
    check("dn_done", int'(done), 1);
    check("dn_busy_cycles", hi, 32);
    cnt = 0;
    for (int t = 0; t < 24; t++) begin
      step();
      if (busy || led_out != '0) cnt++;
    end
    check("dn_nowrap", cnt, 0);

    // Glitch-free update: period with shadow 4, then 8.
    do_reset(1);
    cnt = 0;
    hi = 0;
    for (int t = 0; t < 48; t++) begin
      enable = !(t >= 5 && t <= 12);
      req[0] = (t < 16) || (t >= 24 && t < 28);
      step();
      if (t + 1 >= 17 && t + 1 <= 32 && led_out[0]) hi++;
      if (t + 1 >= 33 && led_out[0]) cnt++;
    end
    check("gl_duty4", hi, 4);
    check("gl_duty8", cnt, 8);

    // Enable low at level 8; tick coincides with reload on re-enable.
    enable = 1'b1;
    req = '0;
    do_reset(1);
    cnt = 0;
    hi = 0;
    for (int t = 0; t < 80; t++) begin
      req[0] = (t < 8);
      enable = !((t == 11) || (t == 15) || (t >= 19 && t <= 59));
      step();
      if (t + 1 == 19) check("en_before", int'(led_out[0]), 1);
      if (t + 1 == 20) check("en_fall", int'(led_out[0]), 0);
      if (t + 1 >= 20 && t + 1 <= 60 && led_out != '0) cnt++;
      if (t + 1 == 60) check("en_hold_busy", int'(busy), 1);
      if (t + 1 >= 65 && led_out[0]) hi++;
    end
    check("en_dark", cnt, 0);
    check("en_resume8", hi, 8);

    // Reset in the middle of a ramp.
    enable = 1'b1;
    req = 6'b000001;
    do_reset(1);
    for (int t = 0; t < 9; t++) step();
    check("mid_busy_pre", int'(busy), 1);
    do_reset(1);
    check("mid_busy", int'(busy), 0);
    check("mid_led", int'(led_out), 0);
    check("mid_ps", int'(period_start), 1);
    req = '0;
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (busy || led_out != '0) cnt++;
    end
    check("mid_cleared", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
